// File: rtl/iq_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_mixer_pkg
// Purpose  : Shared widths and fixed-point helpers for the I/Q mixer/decimator.
// Revision : 1.0  initial release
// ============================================================================
package iq_mixer_pkg;

  localparam int WIDTH_IN     = 16;
  localparam int WIDTH_LO     = 16;
  localparam int WIDTH_OUT    = 16;
  localparam int MAX_DEC_LOG2 = 6;
  localparam int DEC_W        = 3;
  localparam int CNT_W        = MAX_DEC_LOG2;
  localparam int PROD_W       = WIDTH_IN + WIDTH_LO;
  localparam int MIX_W        = 17;
  localparam int ACC_W        = MIX_W + MAX_DEC_LOG2;
  localparam int MIX_SHIFT    = 15;

  localparam logic signed [PROD_W:0] MIX_ROUND = (PROD_W+1)'(1 << (MIX_SHIFT - 1));
  localparam logic signed [ACC_W:0]  OUT_MAX   = (ACC_W+1)'((1 << (WIDTH_OUT - 1)) - 1);
  localparam logic signed [ACC_W:0]  OUT_MIN   = (ACC_W+1)'(-(1 << (WIDTH_OUT - 1)));

  // Q1.15 product back to sample scale; full-scale squared gives +32768, hence 17 bits.
  function automatic logic signed [MIX_W-1:0] mix_round(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] r;
    r = (PROD_W+1)'(p) + MIX_ROUND;
    return r[MIX_SHIFT +: MIX_W];
  endfunction

  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W:0] v,
                                                        input logic [DEC_W-1:0]    k);
    logic signed [ACC_W:0] half;
    half = '0;
    if (k != '0) half[k - 1'b1] = 1'b1;
    return (v + half) >>> k;
  endfunction

  function automatic logic is_clipped(input logic signed [ACC_W:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  function automatic logic signed [WIDTH_OUT-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > OUT_MAX) return OUT_MAX[WIDTH_OUT-1:0];
    if (v < OUT_MIN) return OUT_MIN[WIDTH_OUT-1:0];
    return v[WIDTH_OUT-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_mixer_decimator_integrate_dump.sv
`default_nettype none
// ============================================================================
// Module   : iq_integrate_dump
// Purpose  : One rail of integrate-and-dump: accumulate, round, shift, saturate.
// Revision : 1.0  initial release
// ============================================================================
module iq_integrate_dump
  import iq_mixer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        mix_valid,
  input  logic                        dump,
  input  logic [DEC_W-1:0]            shift,
  input  logic signed [MIX_W-1:0]     mix,
  output logic signed [WIDTH_OUT-1:0] sample,
  output logic                        clip
);

  logic signed [ACC_W-1:0]     r_acc;
  logic signed [WIDTH_OUT-1:0] r_sample;
  logic signed [ACC_W:0]       w_sum;
  logic signed [ACC_W:0]       w_scaled;

  // The dump includes the sample arriving on the dump cycle itself.
  always_comb begin
    w_sum    = (ACC_W+1)'(r_acc) + (ACC_W+1)'(mix);
    w_scaled = round_shift(w_sum, shift);
    clip     = mix_valid && dump && is_clipped(w_scaled);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_sample <= '0;
    end else if (flush) begin
      r_acc <= '0;
    end else if (mix_valid) begin
      if (dump) begin
        r_acc    <= '0;
        r_sample <= saturate(w_scaled);
      end else begin
        r_acc <= ACC_W'(w_sum);
      end
    end
  end

  assign sample = r_sample;

endmodule
`default_nettype wire

// File: rtl/iq_mixer_decimator.sv
`default_nettype none
// ============================================================================
// Module   : iq_mixer_decimator
// Purpose  : Real-to-complex mixer followed by power-of-two integrate-and-dump.
// Revision : 1.0  initial release
// ============================================================================
module iq_mixer_decimator
  import iq_mixer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH_IN-1:0]  adc_data,
  input  logic                 adc_valid,
  input  logic [WIDTH_LO-1:0]  lo_i,
  input  logic [WIDTH_LO-1:0]  lo_q,
  input  logic [DEC_W-1:0]     dec_log2,
  input  logic                 sat_clr,
  output logic [WIDTH_OUT-1:0] out_i,
  output logic [WIDTH_OUT-1:0] out_q,
  output logic                 out_valid,
  output logic                 sat_sticky
);

  localparam logic [DEC_W-1:0] MAX_K = DEC_W'(MAX_DEC_LOG2);

  logic                       r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [WIDTH_IN-1:0] r_adc;
  logic signed [WIDTH_LO-1:0] r_lo_i, r_lo_q;
  logic signed [PROD_W-1:0]   r_p_i, r_p_q;
  logic signed [MIX_W-1:0]    r_mix_i, r_mix_q;
  logic [CNT_W-1:0]           r_cnt;
  logic [DEC_W-1:0]           r_k;
  logic                       r_out_valid;
  logic                       r_sat;

  logic                       w_fire;
  logic                       w_frame_start;
  logic [DEC_W-1:0]           w_req_k;
  logic [DEC_W-1:0]           w_k;
  logic [CNT_W-1:0]           w_cnt_max;
  logic                       w_last;
  logic                       w_clip_i, w_clip_q;
  logic signed [WIDTH_OUT-1:0] w_sample_i, w_sample_q;

  // Ratio is latched only when a frame's first sample reaches the integrator.
  always_comb begin
    w_fire        = r_s3_valid && enable;
    w_frame_start = (r_cnt == '0);
    w_req_k       = (dec_log2 > MAX_K) ? MAX_K : dec_log2;
    w_k           = w_frame_start ? w_req_k : r_k;
    w_cnt_max     = ~({CNT_W{1'b1}} << w_k);
    w_last        = (r_cnt == w_cnt_max);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_s1_valid  <= adc_valid && enable;
      r_s2_valid  <= r_s1_valid && enable;
      r_s3_valid  <= r_s2_valid && enable;
      r_out_valid <= w_fire && w_last;
      if (!enable) begin
        r_cnt <= '0;
      end else if (w_fire) begin
        if (w_frame_start) r_k <= w_req_k;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      // A clip on the same edge as sat_clr keeps the flag set.
      if (w_clip_i || w_clip_q) r_sat <= 1'b1;
      else if (sat_clr)         r_sat <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (adc_valid) begin
      r_adc  <= adc_data;
      r_lo_i <= lo_i;
      r_lo_q <= lo_q;
    end
    if (r_s1_valid) begin
      r_p_i <= r_adc * r_lo_i;
      r_p_q <= r_adc * r_lo_q;
    end
    if (r_s2_valid) begin
      r_mix_i <= mix_round(r_p_i);
      r_mix_q <= mix_round(r_p_q);
    end
  end

  iq_integrate_dump u_rail_i (
    .clk       (clk),
    .reset     (reset),
    .flush     (!enable),
    .mix_valid (w_fire),
    .dump      (w_last),
    .shift     (w_k),
    .mix       (r_mix_i),
    .sample    (w_sample_i),
    .clip      (w_clip_i)
  );

  iq_integrate_dump u_rail_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (!enable),
    .mix_valid (w_fire),
    .dump      (w_last),
    .shift     (w_k),
    .mix       (r_mix_q),
    .sample    (w_sample_q),
    .clip      (w_clip_q)
  );

  assign out_i      = w_sample_i;
  assign out_q      = w_sample_q;
  assign out_valid  = r_out_valid;
  assign sat_sticky = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_iq_mixer_decimator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iq_mixer_decimator
// Purpose  : Scoreboarded random and directed bench for iq_mixer_decimator.
// Revision : 1.0  initial release
// ============================================================================
module tb_iq_mixer_decimator;

  logic        clk = 1'b0;
  logic        reset, enable, adc_valid, sat_clr;
  logic [15:0] adc_data, lo_i, lo_q;
  logic [2:0]  dec_log2;
  logic [15:0] out_i, out_q;
  logic        out_valid, sat_sticky;

  always #5 clk = ~clk;

  iq_mixer_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .lo_i       (lo_i),
    .lo_q       (lo_q),
    .dec_log2   (dec_log2),
    .sat_clr    (sat_clr),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_valid  (out_valid),
    .sat_sticky (sat_sticky)
  );

  typedef struct {
    int ei;
    int eq;
    bit esat;
    int ecyc;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   dumps_exp = 0, dumps_seen = 0;

  // Reference model state: one open frame of mixed samples.
  int m_cnt = 0, m_k = 0, m_si = 0, m_sq = 0;
  bit m_sticky = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int mix_of(int a, int l);
    return $rtoi($floor((real'(a) * real'(l) + 16384.0) / 32768.0));
  endfunction

  function automatic int rescale(int s, int k);
    real half;
    half = (k > 0) ? real'(1 << (k - 1)) : 0.0;
    return $rtoi($floor((real'(s) + half) / real'(1 << k)));
  endfunction

  function automatic int sat16(int v, output bit c);
    c = (v > 32767) || (v < -32768);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_push(int a, int li, int lq, int n);
    exp_t e;
    bit   ci, cq;
    if (m_cnt == 0) begin
      m_k  = (int'(dec_log2) > 6) ? 6 : int'(dec_log2);
      m_si = 0;
      m_sq = 0;
    end
    m_si += mix_of(a, li);
    m_sq += mix_of(a, lq);
    m_cnt++;
    if (m_cnt == (1 << m_k)) begin
      e.ei     = sat16(rescale(m_si, m_k), ci);
      e.eq     = sat16(rescale(m_sq, m_k), cq);
      m_sticky = m_sticky | ci | cq;
      e.esat   = m_sticky;
      e.ecyc   = n + 4;
      sbq.push_back(e);
      dumps_exp++;
      m_cnt = 0;
    end
  endtask

  task automatic drive(bit v, int a, int li, int lq, bit clr = 1'b0);
    @(posedge clk);
    #1;
    adc_valid = v;
    adc_data  = 16'(a);
    lo_i      = 16'(li);
    lo_q      = 16'(lq);
    sat_clr   = clr;
    if (v && enable) model_push(a, li, lq, cyc);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    adc_valid = 1'b0;
    sat_clr   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset    = 1'b0;
    m_cnt    = 0;
    m_si     = 0;
    m_sq     = 0;
    m_sticky = 1'b0;
  endtask

  task automatic flush_frame();
    idle(4);
    @(posedge clk);
    #1;
    enable    = 1'b0;
    adc_valid = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    m_cnt  = 0;
    m_si   = 0;
    m_sq   = 0;
  endtask

  function automatic int rnd16();
    if ($urandom_range(0, 7) == 0) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Monitor: every out_valid must match the oldest expected dump, at the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: actual 1 required 0 (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          dumps_seen++;
          check("out_i", int'($signed(out_i)), e.ei);
          check("out_q", int'($signed(out_q)), e.eq);
          check("sat_sticky_at_dump", int'(sat_sticky), int'(e.esat));
          check("latency_cycle", cyc, e.ecyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, li, lq;
    reset     = 1'b1;
    enable    = 1'b1;
    adc_valid = 1'b0;
    adc_data  = '0;
    lo_i      = '0;
    lo_q      = '0;
    dec_log2  = 3'd0;
    sat_clr   = 1'b0;
    do_reset(3);
    check("reset_out_i", int'(out_i), 0);
    check("reset_out_q", int'(out_q), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sat_sticky", int'(sat_sticky), 0);

    // D=1 rounding case 16383.5 -> 16384, continuous stream.
    repeat (8) drive(1'b1, 16384, 32767, 0);
    idle(6);

    // D=4, continuous then alternate-cycle valids.
    dec_log2 = 3'd2;
    repeat (8) drive(1'b1, 1000, -16384, 16384);
    repeat (8) begin
      drive(1'b1, 1000, -16384, 16384);
      drive(1'b0, 0, 0, 0);
    end
    idle(6);

    // Saturation, sticky clear, and set-beats-clear.
    dec_log2 = 3'd0;
    repeat (4) drive(1'b1, -32768, -32768, 0);
    idle(5);
    check("sat_after_clip", int'(sat_sticky), 1);
    drive(1'b0, 0, 0, 0, 1'b1);
    idle(1);
    m_sticky = 1'b0;
    check("sat_after_clr", int'(sat_sticky), 0);
    for (int i = 0; i < 10; i++) drive(1'b1, -32768, -32768, 0, i == 6);
    idle(6);
    check("sat_set_wins", int'(sat_sticky), 1);

    // Ratio change mid-frame applies to the next frame only.
    dec_log2 = 3'd2;
    repeat (2) drive(1'b1, rnd16(), rnd16(), rnd16());
    idle(4);
    dec_log2 = 3'd1;
    repeat (6) drive(1'b1, rnd16(), rnd16(), rnd16());
    idle(6);

    // enable drop discards a partial frame.
    dec_log2 = 3'd2;
    repeat (3) drive(1'b1, 12000, 30000, -30000);
    flush_frame();
    repeat (4) drive(1'b1, 3000, 20000, 9000);
    idle(6);

    // Reset mid-frame discards the partial sum and zeroes outputs.
    repeat (3) drive(1'b1, 12000, 30000, -30000);
    idle(4);
    do_reset(2);
    check("midreset_out_i", int'(out_i), 0);
    check("midreset_out_q", int'(out_q), 0);
    check("midreset_sat", int'(sat_sticky), 0);
    repeat (3) drive(1'b1, -7000, 25000, 11000);
    idle(4);
    check("postreset_hold_out_i", int'(out_i), 0);
    drive(1'b1, -7000, 25000, 11000);
    idle(6);

    // Randomised batches; the first uses dec_log2=7 to exercise clamping.
    for (int b = 0; b < 10; b++) begin
      dec_log2 = (b == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      for (int c = 0; c < 160; c++) begin
        a  = rnd16();
        li = rnd16();
        lq = rnd16();
        drive($urandom_range(0, 9) < 7, a, li, lq);
      end
      flush_frame();
    end

    idle(8);
    check("scoreboard_empty", sbq.size(), 0);
    check("dump_count", dumps_seen, dumps_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
